// File: rtl/uart_apb_ctrl.sv
// APB UART: byte FIFOs, baud-timed TX/RX FSMs, sticky error flags, maskable irq.
// Define UART_PARITY_EN to build the parity generator/checker and its CTRL/STATUS bits.
module uart_apb_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [4:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_e;

  // ctrl: stop2, par_odd, par_en, rx_en, tx_en; err: parity, frame, overrun
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [2:0] ien_q, ien_d, err_q, err_d;
  logic irq_q, irq_d, tx_q, tx_d;
  logic [DATA_BITS-1:0] txm_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rxm_q [FIFO_DEPTH];
  logic [PW-1:0] txw_q, txw_d, txr_q, txr_d;
  logic [PW-1:0] rxw_q, rxw_d, rxr_q, rxr_d;
  logic [PW-1:0] tx_lvl, rx_lvl;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [DATA_BITS-1:0] tx_head, rx_head;

  st_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_lim_q, tx_lim_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_lim_q, rx_lim_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_par_q, tx_par_d, tx_stp_q, tx_stp_d, rx_bad_q, rx_bad_d;
  logic rs1_q, rs2_q, rs3_q;
  logic tx_pop, tx_rl, tx_end, tx_busy, rx_rl, rx_end;
  logic rx_push, set_fe, set_pe, ovr;
  logic [DIV_WIDTH:0] rx_half;

  logic acc, wr, rd, tx_wr, rx_wr, rx_pop, tx_flush, rx_flush;
  logic [2:0] idx, w1c;
  logic [31:0] rdata;
  logic unused_ok;

  assign unused_ok = ^{paddr_i[1:0], pwdata_i};
  assign idx       = paddr_i[4:2];
  assign acc       = psel_i & penable_i;
  assign wr        = acc & pwrite_i;
  assign rd        = acc & ~pwrite_i;
  assign pready_o  = acc;
  assign tx_o      = tx_q;
  assign irq_o     = irq_q;

  assign tx_lvl   = txw_q - txr_q;
  assign rx_lvl   = rxw_q - rxr_q;
  assign tx_empty = tx_lvl == '0;
  assign rx_empty = rx_lvl == '0;
  assign tx_full  = tx_lvl == PW'(FIFO_DEPTH);
  assign rx_full  = rx_lvl == PW'(FIFO_DEPTH);
  assign tx_head  = txm_q[txr_q[AW-1:0]];
  assign rx_head  = rxm_q[rxr_q[AW-1:0]];
  assign tx_busy  = tx_st_q != S_IDLE;

  assign tx_wr    = wr & (idx == 3'd0) & ~tx_full;
  assign rx_pop   = rd & (idx == 3'd1) & ~rx_empty;
  assign tx_flush = wr & (idx == 3'd3) & pwdata_i[5];
  assign rx_flush = wr & (idx == 3'd3) & pwdata_i[6];
  assign w1c      = (wr && idx == 3'd4) ? pwdata_i[6:4] : 3'd0;
  assign ovr      = rx_push & rx_full & ~rx_pop;
  assign rx_wr    = rx_push & ~ovr;
  assign rx_half  = ({1'b0, rx_lim_q} + (DIV_WIDTH+1)'(1)) >> 1;

  assign pslverr_o = acc & (
    (idx == 3'd0 & pwrite_i & tx_full) |
    (idx == 3'd1 & ~pwrite_i & rx_empty) |
    (idx[2] & idx[1]));

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd1: rdata = rx_empty ? 32'd0 : 32'(rx_head);
      3'd2: rdata = 32'(div_q);
      3'd3: rdata = 32'(ctrl_q);
      3'd4: begin
        rdata[7:0]     = {tx_busy, err_q, rx_full, rx_empty, tx_full, tx_empty};
        rdata[8 +: PW] = rx_lvl;
      end
      3'd5: rdata = 32'(ien_q);
      default: rdata = '0;
    endcase
  end
  assign prdata_o = rd ? rdata : 32'd0;

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    ien_d  = ien_q;
    if (wr && idx == 3'd2) div_d = pwdata_i[DIV_WIDTH-1:0];
    if (wr && idx == 3'd3)
      ctrl_d = {pwdata_i[4], pwdata_i[3] & HAS_PAR,
                pwdata_i[2] & HAS_PAR, pwdata_i[1:0]};
    if (wr && idx == 3'd5) ien_d = pwdata_i[2:0];
    // a flag set in the same cycle as its W1C write wins
    err_d = (err_q & ~w1c) | {set_pe & HAS_PAR, set_fe, ovr};
    irq_d = |(ien_q & {|err_q, tx_empty & ~tx_busy, ~rx_empty});
    txw_d = txw_q + PW'(tx_wr);
    txr_d = txr_q + PW'(tx_pop);
    rxw_d = rxw_q + PW'(rx_wr);
    rxr_d = rxr_q + PW'(rx_pop);
    if (tx_flush) begin txw_d = '0; txr_d = '0; end
    if (rx_flush) begin rxw_d = '0; rxr_d = '0; end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + DIV_WIDTH'(1);
    tx_lim_d = tx_lim_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_stp_d = tx_stp_q;
    tx_pop   = 1'b0;
    tx_rl    = 1'b0;
    tx_end   = tx_cnt_q == tx_lim_q;
    unique case (tx_st_q)
      S_IDLE: begin
        tx_rl    = 1'b1;
        tx_stp_d = 1'b0;
        tx_bit_d = '0;
        if (ctrl_q[0] && !tx_empty) begin
          tx_pop   = 1'b1;
          tx_st_d  = S_START;
          tx_sh_d  = tx_head;
          tx_par_d = ^tx_head;
        end
      end
      S_START: if (tx_end) begin
        tx_rl   = 1'b1;
        tx_st_d = S_DATA;
      end
      S_DATA: if (tx_end) begin
        tx_rl    = 1'b1;
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == BIT_LAST) tx_st_d = ctrl_q[2] ? S_PAR : S_STOP;
      end
      S_PAR: if (tx_end) begin
        tx_rl   = 1'b1;
        tx_st_d = S_STOP;
      end
      S_STOP: if (tx_end) begin
        tx_rl = 1'b1;
        if (ctrl_q[4] && !tx_stp_q) tx_stp_d = 1'b1;
        else tx_st_d = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
    if (tx_rl) begin
      tx_cnt_d = '0;
      tx_lim_d = div_q;
    end
    // line level follows the next state so tx_o lines up with tx_st_q
    unique case (tx_st_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      S_PAR:   tx_d = tx_par_d ^ ctrl_q[3];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
    rx_lim_d = rx_lim_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_bad_d = rx_bad_q;
    rx_push  = 1'b0;
    set_fe   = 1'b0;
    set_pe   = 1'b0;
    rx_rl    = 1'b0;
    rx_end   = rx_cnt_q == rx_lim_q;
    unique case (rx_st_q)
      S_IDLE: begin
        rx_rl    = 1'b1;
        rx_bad_d = 1'b0;
        rx_bit_d = '0;
        if (ctrl_q[1] && rs3_q && !rs2_q) rx_st_d = S_START;
      end
      S_START: if ({1'b0, rx_cnt_q} + (DIV_WIDTH+1)'(1) >= rx_half) begin
        rx_rl   = 1'b1;
        rx_st_d = rs2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_rl    = 1'b1;
        rx_sh_d  = {rs2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == BIT_LAST) rx_st_d = ctrl_q[2] ? S_PAR : S_STOP;
      end
      S_PAR: if (rx_end) begin
        rx_rl   = 1'b1;
        rx_st_d = S_STOP;
        if ((^rx_sh_q ^ rs2_q) != ctrl_q[3]) begin
          rx_bad_d = 1'b1;
          set_pe   = 1'b1;
        end
      end
      S_STOP: if (rx_end) begin
        rx_st_d = S_IDLE;
        if (!rs2_q) set_fe = 1'b1;
        else if (!rx_bad_q) rx_push = 1'b1;
      end
      default: rx_st_d = S_IDLE;
    endcase
    if (rx_rl) begin
      rx_cnt_d = '0;
      rx_lim_d = div_q;
    end
    if (!ctrl_q[1]) rx_st_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (tx_wr) txm_q[txw_q[AW-1:0]] <= pwdata_i[DATA_BITS-1:0];
    if (rx_wr) rxm_q[rxw_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '1; ctrl_q <= '0; ien_q <= '0; err_q <= '0;
      irq_q <= 1'b0; tx_q <= 1'b1;
      txw_q <= '0; txr_q <= '0; rxw_q <= '0; rxr_q <= '0;
      tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_lim_q <= '0;
      tx_bit_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0; tx_stp_q <= 1'b0;
      rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_lim_q <= '0;
      rx_bit_q <= '0; rx_sh_q <= '0; rx_bad_q <= 1'b0;
      rs1_q <= 1'b1; rs2_q <= 1'b1; rs3_q <= 1'b1;
    end else begin
      div_q <= div_d; ctrl_q <= ctrl_d; ien_q <= ien_d; err_q <= err_d;
      irq_q <= irq_d; tx_q <= tx_d;
      txw_q <= txw_d; txr_q <= txr_d; rxw_q <= rxw_d; rxr_q <= rxr_d;
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_lim_q <= tx_lim_d;
      tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d;
      tx_stp_q <= tx_stp_d;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_lim_q <= rx_lim_d;
      rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d; rx_bad_q <= rx_bad_d;
      rs1_q <= rx_i; rs2_q <= rs1_q; rs3_q <= rs2_q;
    end
  end
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Randomized bench for uart_apb_ctrl against a queue-based behavioural model.
module tb_uart_apb_ctrl;
  localparam int DB = 8;
  localparam int DEPTH = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic psel = 1'b0, pen = 1'b0, pwr = 1'b0, rx = 1'b1;
  logic [4:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr, tx, irq;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_apb_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(pen),
    .pwrite_i(pwr), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .rx_i(rx), .tx_o(tx), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input int idx, input logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 5'(idx * 4); pwdata = d;
    @(negedge clk);
    pen = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; pen = 1'b0; pwr = 1'b0;
  endtask

  task automatic apb_rd(input int idx, output logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pen = 1'b0; pwr = 1'b0; paddr = 5'(idx * 4);
    @(negedge clk);
    pen = 1'b1;
    #1 d = prdata; err = pslverr;
    chk("pready", {31'd0, pready}, 32'd1);
    @(posedge clk);
    #1 psel = 1'b0; pen = 1'b0;
  endtask

  // capture nb bit periods of p clocks starting at the next low level on tx
  task automatic tx_cap(input int p, input int nb, output logic [15:0] bits,
                        output bit clean, output bit ok);
    int t = 0;
    logic v0;
    ok = 1'b1; clean = 1'b1; bits = '0;
    @(negedge clk);
    while (tx !== 1'b0) begin
      t++;
      if (t > 20000) begin ok = 1'b0; return; end
      @(negedge clk);
    end
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k > 0 || j > 0) @(negedge clk);
        if (j == 0) v0 = tx;
        if (tx !== v0) clean = 1'b0;
        if (j == p / 2) bits[k] = tx;
      end
    end
  endtask

  // par < 0: no parity bit, otherwise par[0] is sent as the parity bit
  task automatic rx_send(input logic [7:0] b, input int p, input int par,
                         input logic stp);
    @(negedge clk);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    if (par >= 0) begin
      rx = par[0];
      repeat (p) @(negedge clk);
    end
    rx = stp;
    repeat (p) @(negedge clk);
    rx = 1'b1;
    repeat (p) @(negedge clk);
  endtask

  // STATUS with TX idle and empty, derived from the RX model state
  function automatic logic [31:0] st_exp(int lvl, bit ov, bit fe, bit pe);
    logic [31:0] s;
    s = 32'(lvl) << 8;
    s |= {25'd0, pe, fe, ov, (lvl == DEPTH), (lvl == 0), 1'b0, 1'b1};
    return s;
  endfunction

  initial begin
    logic [31:0] d;
    logic e;
    logic [15:0] bits;
    bit cl, ok, low_seen, ov;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] b, exp_b;
    logic [8:0] errs;
    int p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("idle_prdata", prdata, 32'd0);
    chk("idle_pslverr", {31'd0, pslverr}, 32'd0);
    apb_rd(4, d, e); chk("rst_status", d, st_exp(0, 0, 0, 0));
    apb_rd(2, d, e); chk("rst_clkdiv", d, 32'h0000_ffff);
    apb_rd(3, d, e); chk("rst_ctrl", d, 32'd0);
    apb_rd(5, d, e); chk("rst_irqen", d, 32'd0);
    apb_wr(6, 32'hffff_ffff, e); chk("bad_wr_err", {31'd0, e}, 32'd1);
    apb_rd(7, d, e);
    chk("bad_rd_data", d, 32'd0);
    chk("bad_rd_err", {31'd0, e}, 32'd1);

    // single frame, exact waveform and interrupt lag
    apb_wr(2, 32'd3, e);
    apb_wr(5, 32'd2, e);
    apb_wr(3, 32'd1, e);
    apb_wr(0, 32'hA5, e);
    tx_cap(4, 10, bits, cl, ok);
    chk("tx_a5_timeout", {31'd0, ok}, 32'd1);
    chk("tx_a5_wave", {16'd0, bits}, {22'd0, 1'b1, 8'hA5, 1'b0});
    chk("tx_a5_clean", {31'd0, cl}, 32'd1);
    @(negedge clk); chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk); chk("irq_rise", {31'd0, irq}, 32'd1);
    apb_rd(4, d, e); chk("tx_idle_status", d, st_exp(0, 0, 0, 0));

    // fill TX past full with TX disabled, then drain
    apb_wr(3, 32'd0, e);
    apb_wr(5, 32'd0, e);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      apb_wr(0, {24'd0, b}, e);
      errs[i] = e;
      if (txq.size() < DEPTH) txq.push_back(b);
    end
    chk("tx_push_err", {23'd0, errs}, 32'h100);
    apb_rd(4, d, e); chk("tx_full_flags", d & 32'h3, 32'h2);
    p = $urandom_range(2, 6);
    apb_wr(2, 32'(p - 1), e);
    apb_wr(3, 32'd1, e);
    for (int i = 0; i < DEPTH; i++) begin
      tx_cap(p, 10, bits, cl, ok);
      chk("tx_q_timeout", {31'd0, ok}, 32'd1);
      exp_b = txq.pop_front();
      chk("tx_q_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
      chk("tx_q_frame", {30'd0, bits[9], bits[0]}, 32'd2);
      chk("tx_q_clean", {31'd0, cl}, 32'd1);
    end
    low_seen = 1'b0;
    repeat (30 * p) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("tx_no_extra", {31'd0, low_seen}, 32'd0);

    // TX flush
    apb_wr(3, 32'd0, e);
    repeat (3) apb_wr(0, $urandom, e);
    apb_wr(3, 32'h20, e);
    apb_rd(4, d, e); chk("tx_flush", d, st_exp(0, 0, 0, 0));
    apb_rd(3, d, e); chk("flush_reads0", d, 32'd0);

    // RX single bytes
    apb_wr(2, 32'd7, e);
    apb_wr(3, 32'd2, e);
    rx_send(8'h3C, 8, -1, 1'b1);
    apb_rd(4, d, e); chk("rx_lvl1", d, st_exp(1, 0, 0, 0));
    apb_rd(1, d, e);
    chk("rx_3c", d, 32'h3C);
    chk("rx_3c_err", {31'd0, e}, 32'd0);
    apb_rd(4, d, e); chk("rx_drained", d, st_exp(0, 0, 0, 0));
    apb_rd(1, d, e);
    chk("rx_empty_data", d, 32'd0);
    chk("rx_empty_err", {31'd0, e}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(4, 10);
      b = 8'($urandom);
      apb_wr(2, 32'(p - 1), e);
      rx_send(b, p, -1, 1'b1);
      apb_rd(1, d, e); chk("rx_rand", d, {24'd0, b});
    end

    // RX overrun
    apb_wr(2, 32'd7, e);
    apb_wr(5, 32'd1, e);
    ov = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      rx_send(b, 8, -1, 1'b1);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else ov = 1'b1;
    end
    apb_rd(4, d, e); chk("ovr_status", d, st_exp(rxq.size(), ov, 0, 0));
    chk("irq_rx_avail", {31'd0, irq}, 32'd1);
    apb_wr(4, 32'h10, e);
    apb_rd(4, d, e); chk("ovr_w1c", d, st_exp(rxq.size(), 0, 0, 0));
    while (rxq.size() > 0) begin
      exp_b = rxq.pop_front();
      apb_rd(1, d, e); chk("ovr_data", d, {24'd0, exp_b});
    end
    repeat (2) @(negedge clk);
    chk("irq_rx_clear", {31'd0, irq}, 32'd0);

    // frame error and glitch rejection
    apb_wr(5, 32'd4, e);
    rx_send(8'($urandom), 8, -1, 1'b0);
    apb_rd(4, d, e); chk("frame_err", d, st_exp(0, 0, 1, 0));
    chk("irq_err", {31'd0, irq}, 32'd1);
    apb_wr(4, 32'h20, e);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    apb_rd(4, d, e); chk("glitch", d, st_exp(0, 0, 0, 0));

`ifdef UART_PARITY_EN
    apb_wr(2, 32'd3, e);
    apb_wr(3, 32'h0D, e);
    apb_rd(3, d, e); chk("par_ctrl", d, 32'h0D);
    apb_wr(0, 32'h01, e);
    tx_cap(4, 11, bits, cl, ok);
    chk("par_tx_timeout", {31'd0, ok}, 32'd1);
    chk("par_tx_wave", {16'd0, bits}, 32'h402);
    apb_wr(3, 32'h0E, e);
    rx_send(8'h55, 4, 0, 1'b1);
    apb_rd(4, d, e); chk("par_err", d, st_exp(0, 0, 0, 1));
    apb_wr(4, 32'h40, e);
    rx_send(8'h55, 4, 1, 1'b1);
    apb_rd(1, d, e); chk("par_good", d, 32'h55);
`else
    apb_wr(3, 32'h0D, e);
    apb_rd(3, d, e); chk("nopar_ctrl", d, 32'h01);
`endif

    // reset in the middle of a frame
    apb_wr(2, 32'd7, e);
    apb_wr(3, 32'd1, e);
    apb_wr(0, 32'h00, e);
    repeat (20) @(negedge clk);
    chk("pre_rst_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    apb_rd(4, d, e); chk("rst_mid_status", d, st_exp(0, 0, 0, 0));
    apb_rd(2, d, e); chk("rst_mid_div", d, 32'h0000_ffff);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
